// File: rtl/dcache_flush_responder_pkg.sv
// Shared types for the cache flush handshake.
// Phase encoding plus writeback address composition.
package CacheSystemTypes;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_READ,
        FR_CHECK,
        FR_WB,
        FR_DONE,
        FR_HOLD
    } FlushRespPhase;

    // {tag, index, zero offset}; caller truncates to its address width
    function automatic logic [63:0] FLUSH_WB_ADDR(
        input logic [63:0] tag,
        input logic [63:0] idx,
        input int          idxW,
        input int          offW
    );
        logic [63:0] a;
        a = (tag << idxW) | idx;
        return a << offW;
    endfunction

endpackage

// File: rtl/dcache_flush_responder_way_picker.sv
// Lowest-set-bit priority encoder over the pending writeback mask.
// Reports the chosen way and whether any bit is set.
module flush_way_picker #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0]  pending,
    output logic [WAY_W-1:0] way,
    output logic             any
);

    always_comb begin
        way = '0;
        any = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                way = WAY_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_flush_responder.sv
// Cache-side flush walker: reads every set, writes back dirty
// ways, invalidates, signals completion and holds until released.
module dcache_flush_responder
    import CacheSystemTypes::*;
#(
    parameter int SETS     = 64,
    parameter int WAYS     = 2,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 4,
    localparam int IDX_W   = $clog2(SETS),
    localparam int TAG_W   = ADDR_W - IDX_W - OFFSET_W,
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    flushReq,
    output logic                    flushReqAck,
    output logic                    flushComplete,
    input  logic                    flushAllComplete,
    input  logic                    cacheBusy,
    output logic                    flushing,
    output logic                    tagRdEn,
    output logic [IDX_W-1:0]        tagRdIndex,
    input  logic [WAYS-1:0]         tagRdValid,
    input  logic [WAYS-1:0]         tagRdDirty,
    input  logic [WAYS*TAG_W-1:0]   tagRdTag,
    output logic                    wbReq,
    input  logic                    wbAck,
    output logic [ADDR_W-1:0]       wbAddr,
    output logic [WAY_W-1:0]        wbWay,
    output logic                    invEn
);

    FlushRespPhase state;

    logic [IDX_W-1:0]      index;
    logic [WAYS-1:0]       pendingQ;
    logic [WAYS*TAG_W-1:0] tagsQ;
    logic                  fresh;

    logic [WAYS-1:0]       curPending;
    logic [WAYS*TAG_W-1:0] curTags;
    logic [WAY_W-1:0]      pickWay;
    logic                  pickAny;
    logic [TAG_W-1:0]      pickTag;

    // Array data is live only on the first CHECK after READ
    assign curPending = fresh ? (tagRdValid & tagRdDirty) : pendingQ;
    assign curTags    = fresh ? tagRdTag : tagsQ;
    assign pickTag    = curTags[int'(pickWay)*TAG_W +: TAG_W];

    flush_way_picker #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) uPicker (
        .pending (curPending),
        .way     (pickWay),
        .any     (pickAny)
    );

    assign flushReqAck   = (state == FR_IDLE) && !cacheBusy;
    assign flushing      = (state != FR_IDLE);
    assign tagRdEn       = (state == FR_READ);
    assign tagRdIndex    = index;
    assign flushComplete = (state == FR_DONE);
    assign invEn         = (state == FR_CHECK) && !pickAny;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= FR_IDLE;
            index    <= '0;
            pendingQ <= '0;
            tagsQ    <= '0;
            fresh    <= 1'b0;
            wbReq    <= 1'b0;
            wbAddr   <= '0;
            wbWay    <= '0;
        end else begin
            unique case (state)
                FR_IDLE: begin
                    if (flushReq && !cacheBusy) begin
                        index <= '0;
                        state <= FR_READ;
                    end
                end
                FR_READ: begin
                    fresh <= 1'b1;
                    state <= FR_CHECK;
                end
                FR_CHECK: begin
                    fresh    <= 1'b0;
                    pendingQ <= curPending;
                    tagsQ    <= curTags;
                    if (pickAny) begin
                        wbReq  <= 1'b1;
                        wbWay  <= pickWay;
                        wbAddr <= ADDR_W'(FLUSH_WB_ADDR(
                            64'(pickTag), 64'(index),
                            IDX_W, OFFSET_W));
                        state  <= FR_WB;
                    end else if (index == IDX_W'(SETS - 1)) begin
                        state <= FR_DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= FR_READ;
                    end
                end
                FR_WB: begin
                    if (wbAck) begin
                        wbReq    <= 1'b0;
                        pendingQ <= pendingQ & ~(WAYS'(1) << wbWay);
                        state    <= FR_CHECK;
                    end
                end
                FR_DONE: state <= FR_HOLD;
                FR_HOLD: begin
                    if (flushAllComplete) state <= FR_IDLE;
                end
                default: state <= FR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_flush_responder.sv
// Bench for dcache_flush_responder: behavioural tag array,
// writeback scoreboard built from array contents, timing checks.
module tb_dcache_flush_responder;

    localparam int SETS     = 64;
    localparam int WAYS     = 2;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int IDX_W    = 6;
    localparam int TAG_W    = ADDR_W - IDX_W - OFFSET_W;
    localparam int WAY_W    = 1;

    logic                  clk;
    logic                  rstN;
    logic                  flushReq;
    logic                  flushReqAck;
    logic                  flushComplete;
    logic                  flushAllComplete;
    logic                  cacheBusy;
    logic                  flushing;
    logic                  tagRdEn;
    logic [IDX_W-1:0]      tagRdIndex;
    logic [WAYS-1:0]       tagRdValid;
    logic [WAYS-1:0]       tagRdDirty;
    logic [WAYS*TAG_W-1:0] tagRdTag;
    logic                  wbReq;
    logic                  wbAck;
    logic [ADDR_W-1:0]     wbAddr;
    logic [WAY_W-1:0]      wbWay;
    logic                  invEn;

    dcache_flush_responder #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) dut (
        .clk              (clk),
        .rstN             (rstN),
        .flushReq         (flushReq),
        .flushReqAck      (flushReqAck),
        .flushComplete    (flushComplete),
        .flushAllComplete (flushAllComplete),
        .cacheBusy        (cacheBusy),
        .flushing         (flushing),
        .tagRdEn          (tagRdEn),
        .tagRdIndex       (tagRdIndex),
        .tagRdValid       (tagRdValid),
        .tagRdDirty       (tagRdDirty),
        .tagRdTag         (tagRdTag),
        .wbReq            (wbReq),
        .wbAck            (wbAck),
        .wbAddr           (wbAddr),
        .wbWay            (wbWay),
        .invEn            (invEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WAY_W-1:0]  way;
    } wbRec_t;

    typedef struct {
        bit busy;
        bit req;
        bit expAck;
        bit expAccept;
    } vec_t;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    bit               vld [SETS][WAYS];
    bit               drt [SETS][WAYS];
    logic [TAG_W-1:0] tg  [SETS][WAYS];
    wbRec_t           expQ[$];

    int ackDelay = 0;
    int waitCnt  = 0;
    bit randAck  = 0;
    bit ackForce = 0;
    int invCnt   = 0;
    int wbCnt    = 0;
    int doneCnt  = 0;

    bit                holdV = 0;
    logic [ADDR_W-1:0] hAddr;
    logic [WAY_W-1:0]  hWay;

    assign wbAck = ackForce || (wbReq && (waitCnt >= ackDelay));

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor at negedge, array and ack-counter updates after posedge
    task automatic tick();
        bit capRd, capInv, capHs, capStall;
        logic [IDX_W-1:0] capIdx;
        wbRec_t r;
        @(negedge clk);
        capRd    = tagRdEn;
        capInv   = invEn;
        capIdx   = tagRdIndex;
        capHs    = wbReq && wbAck;
        capStall = wbReq && !wbAck;
        if (invEn) invCnt++;
        if (flushComplete) doneCnt++;
        if (holdV) begin
            chk("wb-held-req", wbReq, 1);
            chk("wb-held-addr", wbAddr, hAddr);
            chk("wb-held-way", wbWay, hWay);
        end
        holdV = capStall;
        hAddr = wbAddr;
        hWay  = wbWay;
        if (capHs) begin
            wbCnt++;
            if (expQ.size() == 0) begin
                chk("wb-unexpected", 1, 0);
            end else begin
                r = expQ.pop_front();
                chk("wb-addr", wbAddr, r.addr);
                chk("wb-way", wbWay, r.way);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (capInv) begin
            for (int w = 0; w < WAYS; w++) begin
                vld[capIdx][w] = 0;
                drt[capIdx][w] = 0;
            end
        end
        if (capRd) begin
            for (int w = 0; w < WAYS; w++) begin
                tagRdValid[w] = vld[capIdx][w];
                tagRdDirty[w] = drt[capIdx][w];
                tagRdTag[w*TAG_W +: TAG_W] = tg[capIdx][w];
            end
        end
        if (capStall) waitCnt++;
        if (capHs) begin
            waitCnt = 0;
            if (randAck) ackDelay = $urandom_range(0, 3);
        end
    endtask

    task automatic clearRam();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                vld[s][w] = 0;
                drt[s][w] = 0;
                tg[s][w]  = '0;
            end
    endtask

    task automatic setLine(input int s, input int w, input bit v,
                           input bit d, input logic [TAG_W-1:0] t);
        vld[s][w] = v;
        drt[s][w] = d;
        tg[s][w]  = t;
    endtask

    // Expected writebacks: set order, lowest way first, valid&dirty only
    task automatic buildExp();
        wbRec_t r;
        logic [63:0] a;
        expQ.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (vld[s][w] && drt[s][w]) begin
                    a = (64'(tg[s][w]) << (IDX_W + OFFSET_W))
                      | (64'(s) << OFFSET_W);
                    r.addr = a[ADDR_W-1:0];
                    r.way  = WAY_W'(w);
                    expQ.push_back(r);
                end
    endtask

    task automatic doFlush(input string name, output int dur);
        int acc;
        int left;
        invCnt = 0;
        wbCnt  = 0;
        buildExp();
        flushReq = 1;
        acc = cyc;
        tick();
        flushReq = 0;
        chk({name, "-accepted"}, flushing, 1);
        chk({name, "-read0"}, {tagRdEn, tagRdIndex}, {1'b1, 6'd0});
        dur = -1;
        for (int i = 0; i < 20000; i++) begin
            if (flushComplete) begin
                dur = cyc - acc;
                break;
            end
            tick();
        end
        chk({name, "-complete-seen"}, dur >= 0, 1);
        chk({name, "-wb-left"}, expQ.size(), 0);
        chk({name, "-inv-count"}, invCnt, SETS);
        left = 0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (vld[s][w]) left++;
        chk({name, "-valid-left"}, left, 0);
    endtask

    task automatic releaseHold(input string name);
        tick();
        flushAllComplete = 1;
        tick();
        flushAllComplete = 0;
        chk({name, "-released"}, flushing, 0);
    endtask

    initial begin
        vec_t vecs[4];
        int d0, d7, dur, b;

        vecs[0] = '{busy: 0, req: 0, expAck: 1, expAccept: 0};
        vecs[1] = '{busy: 1, req: 0, expAck: 0, expAccept: 0};
        vecs[2] = '{busy: 1, req: 1, expAck: 0, expAccept: 0};
        vecs[3] = '{busy: 0, req: 1, expAck: 1, expAccept: 1};

        rstN = 0;
        flushReq = 0;
        flushAllComplete = 0;
        cacheBusy = 0;
        tagRdValid = '0;
        tagRdDirty = '0;
        tagRdTag = '0;
        clearRam();
        tick();
        tick();
        chk("rst-flushing", flushing, 0);
        chk("rst-ack", flushReqAck, 1);
        chk("rst-rden", tagRdEn, 0);
        chk("rst-index", tagRdIndex, 0);
        chk("rst-wbreq", wbReq, 0);
        chk("rst-wbaddr", wbAddr, 0);
        chk("rst-inv", invEn, 0);
        chk("rst-complete", flushComplete, 0);
        cacheBusy = 1;
        #1;
        chk("rst-ack-busy", flushReqAck, 0);
        cacheBusy = 0;
        rstN = 1;
        tick();

        // Request acceptance against cacheBusy
        foreach (vecs[i]) begin
            cacheBusy = vecs[i].busy;
            flushReq  = vecs[i].req;
            #1;
            chk($sformatf("vec%0d-ack", i), flushReqAck, vecs[i].expAck);
            tick();
            flushReq  = 0;
            cacheBusy = 0;
            chk($sformatf("vec%0d-accept", i), flushing,
                vecs[i].expAccept);
            if (flushing) begin
                rstN = 0;
                #1;
                rstN = 1;
            end
            tick();
        end

        // Clean cache timing, then DONE-cycle release is ignored
        clearRam();
        doFlush("clean", dur);
        chk("clean-duration", dur, 1 + 2 * SETS);
        chk("clean-wb-count", wbCnt, 0);
        flushAllComplete = 1;
        tick();
        flushAllComplete = 0;
        chk("done-release-ignored", flushing, 1);
        b = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!flushing) b++;
        end
        chk("hold-20-cycles", b, 0);
        chk("hold-no-ack", flushReqAck, 0);
        flushAllComplete = 1;
        tick();
        flushAllComplete = 0;
        chk("hold-exit-flushing", flushing, 0);
        chk("hold-exit-ack", flushReqAck, 1);

        // Set 5 two dirty ways, immediate ack
        clearRam();
        setLine(5, 0, 1, 1, 22'h123);
        setLine(5, 1, 1, 1, 22'h456);
        setLine(9, 1, 0, 1, 22'h3ff);
        setLine(12, 0, 1, 0, 22'h2aa);
        doFlush("set5", dur);
        chk("set5-wb-count", wbCnt, 2);
        releaseHold("set5");

        // Stall cost of a single writeback
        ackForce = 1;
        tick();
        ackForce = 0;
        chk("spurious-ack", wbReq, 0);
        clearRam();
        setLine(5, 1, 1, 1, 22'h0abc);
        ackDelay = 0;
        doFlush("stall0", d0);
        releaseHold("stall0");
        clearRam();
        setLine(5, 1, 1, 1, 22'h0abc);
        ackDelay = 7;
        doFlush("stall7", d7);
        releaseHold("stall7");
        chk("stall-shift", d7 - d0, 7);
        ackDelay = 0;

        // Reset in the middle of the walk
        clearRam();
        doneCnt = 0;
        flushReq = 1;
        tick();
        flushReq = 0;
        b = 0;
        for (int i = 0; i < 500; i++) begin
            if (tagRdIndex == 6'd30) begin
                b = 1;
                break;
            end
            tick();
        end
        chk("midwalk-reached", b, 1);
        #2;
        rstN = 0;
        #1;
        chk("midwalk-rst-flushing", flushing, 0);
        chk("midwalk-rst-index", tagRdIndex, 0);
        chk("midwalk-rst-rden", tagRdEn, 0);
        chk("midwalk-rst-inv", invEn, 0);
        chk("midwalk-rst-ack", flushReqAck, 1);
        tick();
        rstN = 1;
        holdV = 0;
        waitCnt = 0;
        for (int i = 0; i < 150; i++) tick();
        chk("midwalk-no-complete", doneCnt, 0);
        setLine(0, 1, 1, 1, 22'h00077);
        setLine(63, 0, 1, 1, 22'h3fffff);
        doFlush("restart", dur);
        chk("restart-wb-count", wbCnt, 2);
        releaseHold("restart");

        // Random contents with random ack latency
        randAck = 1;
        for (int n = 0; n < 3; n++) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    setLine(s, w, 1'($urandom), 1'($urandom),
                            TAG_W'($urandom));
            cacheBusy = 1;
            tick();
            tick();
            cacheBusy = 0;
            doFlush($sformatf("rand%0d", n), dur);
            releaseHold($sformatf("rand%0d", n));
        end
        randAck = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
